// File: rtl/mips_fetch_ctrl.sv
// mips_fetch_ctrl: instruction fetch controller with a small prefetch buffer.
// Owns the PC, drives the combinational instruction memory, buffers {pc, inst}
// pairs and hands them downstream over valid/ready. Redirects flush and reload.
// Optional performance counters are enabled with `define MIPS_FETCH_PERF_EN.
module mips_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_run,
  output logic [31:0] o_imem_pc,
  input  logic [31:0] i_imem_inst,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
`ifdef MIPS_FETCH_PERF_EN
  output logic [31:0] o_perf_fetch_cnt,
  output logic [31:0] o_perf_flush_cnt,
`endif
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_out_pc,
  output logic [31:0] o_out_inst
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [31:0]      r_pc;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_buf_pc   [DEPTH];
  logic [31:0]      r_buf_inst [DEPTH];

  logic [31:0]      w_pc_d;
  logic [PTR_W-1:0] w_head_d;
  logic [PTR_W-1:0] w_tail_d;
  logic [CNT_W-1:0] w_count_d;
  logic             w_pop;
  logic             w_push;
  logic             w_unused;

  // Low redirect bits are forced to zero, so they are intentionally dropped.
  assign w_unused = ^i_redirect_pc[1:0];

  assign o_imem_pc   = r_pc;
  assign o_out_valid = (r_count != '0);
  assign o_out_pc    = r_buf_pc[r_head];
  assign o_out_inst  = r_buf_inst[r_head];

  assign w_pop  = o_out_valid & i_out_ready;
  // A full buffer can still accept when the head leaves in the same cycle.
  assign w_push = i_run & ~i_redirect_valid & ((r_count < DEPTH_C) | w_pop);

  // Next-state for PC and buffer bookkeeping; redirect overrides everything.
  always_comb begin
    w_pc_d    = r_pc;
    w_head_d  = r_head;
    w_tail_d  = r_tail;
    w_count_d = r_count;
    if (i_redirect_valid) begin
      w_pc_d    = {i_redirect_pc[31:2], 2'b00};
      w_head_d  = '0;
      w_tail_d  = '0;
      w_count_d = '0;
    end else begin
      if (w_push) begin
        w_pc_d   = r_pc + 32'd4;
        w_tail_d = r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        w_head_d = r_head + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   w_count_d = r_count + CNT_W'(1);
        2'b01:   w_count_d = r_count - CNT_W'(1);
        default: w_count_d = r_count;
      endcase
    end
  end

  // PC, pointers, occupancy and buffer storage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc    <= RESET_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_buf_pc[i]   <= '0;
        r_buf_inst[i] <= '0;
      end
    end else begin
      r_pc    <= w_pc_d;
      r_head  <= w_head_d;
      r_tail  <= w_tail_d;
      r_count <= w_count_d;
      if (w_push) begin
        r_buf_pc[r_tail]   <= r_pc;
        r_buf_inst[r_tail] <= i_imem_inst;
      end
    end
  end

`ifdef MIPS_FETCH_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_flush;

  // Free-running event counters: pushes and redirect cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_perf_fetch <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_push) r_perf_fetch <= r_perf_fetch + 32'd1;
      if (i_redirect_valid) r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign o_perf_fetch_cnt = r_perf_fetch;
  assign o_perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_mips_fetch_ctrl.sv
// Directed testbench for mips_fetch_ctrl with a combinational memory model
// returning inst = pc ^ 32'hA5A5_0000.
module tb_mips_fetch_ctrl;

  localparam logic [31:0] INST_XOR = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
`ifdef MIPS_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  assign imem_inst = imem_pc ^ INST_XOR;

  mips_fetch_ctrl #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2)
  ) u_dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_run           (run),
    .o_imem_pc       (imem_pc),
    .i_imem_inst     (imem_inst),
    .i_redirect_valid(redirect_valid),
    .i_redirect_pc   (redirect_pc),
`ifdef MIPS_FETCH_PERF_EN
    .o_perf_fetch_cnt(perf_fetch_cnt),
    .o_perf_flush_cnt(perf_flush_cnt),
`endif
    .o_out_valid     (out_valid),
    .i_out_ready     (out_ready),
    .o_out_pc        (out_pc),
    .o_out_inst      (out_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges; leaves rst_n released before the next edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    run            = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #1;
    check_eq("rst_imem_pc", imem_pc, 32'h0);
    check_eq("rst_valid", 32'(out_valid), 32'h0);
    check_eq("rst_out_pc", out_pc, 32'h0);
    check_eq("rst_out_inst", out_inst, 32'h0);
`ifdef MIPS_FETCH_PERF_EN
    check_eq("rst_perf_fetch", perf_fetch_cnt, 32'h0);
    check_eq("rst_perf_flush", perf_flush_cnt, 32'h0);
`endif
    tick();
    rst_n     = 1'b1;
    run       = 1'b1;
    out_ready = 1'b1;

    // Streaming: one instruction per cycle, no gaps.
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("stream_valid", 32'(out_valid), 32'h1);
      check_eq("stream_pc", out_pc, 32'(4 * i));
      check_eq("stream_inst", out_inst, 32'(4 * i) ^ INST_XOR);
    end

    // Stall: buffer fills with 0, 4 and PC holds at 8.
    do_reset();
    out_ready = 1'b0;
    check_eq("post_rst_imem_pc", imem_pc, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("stall_out_pc", out_pc, 32'h0);
    end
    check_eq("stall_imem_pc", imem_pc, 32'h8);
    check_eq("stall_valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      check_eq("release_pc", out_pc, 32'(4 * i));
      check_eq("release_inst", out_inst, 32'(4 * i) ^ INST_XOR);
    end

    // Redirect from a full buffer; low target bits are dropped.
    do_reset();
    out_ready = 1'b0;
    tick();
    tick();
    check_eq("full_imem_pc", imem_pc, 32'h8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    tick();
    redirect_valid = 1'b0;
    check_eq("redir_valid", 32'(out_valid), 32'h0);
    check_eq("redir_imem_pc", imem_pc, 32'h40);
    tick();
    check_eq("redir_tgt_valid", 32'(out_valid), 32'h1);
    check_eq("redir_tgt_pc", out_pc, 32'h40);
    check_eq("redir_tgt_inst", out_inst, 32'h40 ^ INST_XOR);

    // Redirect to the top of the address space; PC wraps to 0.
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    check_eq("wrap_imem_pc", imem_pc, 32'hFFFF_FFFC);
    tick();
    check_eq("wrap_pc0", out_pc, 32'hFFFF_FFFC);
    tick();
    check_eq("wrap_pc1", out_pc, 32'h0);
    check_eq("wrap_imem_next", imem_pc, 32'h4);

    // run=0 drains the buffer while the PC stays put.
    do_reset();
    out_ready = 1'b0;
    tick();
    tick();
    run       = 1'b0;
    out_ready = 1'b1;
    check_eq("drain_pc0", out_pc, 32'h0);
    tick();
    check_eq("drain_valid1", 32'(out_valid), 32'h1);
    check_eq("drain_pc1", out_pc, 32'h4);
    check_eq("drain_imem1", imem_pc, 32'h8);
    tick();
    check_eq("drain_empty", 32'(out_valid), 32'h0);
    check_eq("drain_imem2", imem_pc, 32'h8);
    tick();
    check_eq("idle_imem", imem_pc, 32'h8);

    // Redirect while not running still loads the PC.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check_eq("norun_redir_pc", imem_pc, 32'h100);
    check_eq("norun_redir_valid", 32'(out_valid), 32'h0);

    // Asynchronous reset mid-stream, observed before the next edge.
    run = 1'b1;
    tick();
    tick();
    tick();
    check_eq("pre_async_valid", 32'(out_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_valid", 32'(out_valid), 32'h0);
    check_eq("async_imem_pc", imem_pc, 32'h0);
    check_eq("async_out_pc", out_pc, 32'h0);
    #1;
    rst_n = 1'b1;

`ifdef MIPS_FETCH_PERF_EN
    // Three pushes then one redirect cycle without a push.
    do_reset();
    tick();
    tick();
    tick();
    run            = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    tick();
    redirect_valid = 1'b0;
    check_eq("perf_fetch", perf_fetch_cnt, 32'd3);
    check_eq("perf_flush", perf_flush_cnt, 32'd1);
    do_reset();
    check_eq("perf_fetch_rst", perf_fetch_cnt, 32'd0);
    check_eq("perf_flush_rst", perf_flush_cnt, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
